prime_scan: RTL
===============

# prime_scan

Sequential range scanner that sits directly upstream of the 4-bit `primes` classifier. On a start request it drives each value of an inclusive range `lo..hi` onto the classifier's `x` input, one per clock, and samples the classifier's combinational `z` result. It counts the primes found, reports each one as it is found, and signals completion with a one-cycle `done` pulse. It is the test/driver stage that turns the combinational classifier into a usable run-to-completion unit.

## Interface
- `W`, default 4: width of scanned value; must match the classifier input width.
- `clk` input 1: system clock, rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: scan request, sampled only in IDLE.
- `lo` input W: first value of range, sampled with `start`.
- `hi` input W: last value of range (inclusive), sampled with `start`.
- `x` output W: value presented to classifier (registered).
- `z` input 1: classifier result for current `x` (combinational, same cycle).
- `busy` output 1: high in SCAN.
- `done` output 1: one-cycle completion pulse.
- `count` output W+1: number of primes found in last/current scan.
- `hit` output 1: one-cycle pulse, a prime was found.
- `hit_val` output W: value of the prime flagged by `hit`.
- `max_prime` output W: largest prime found (see Configuration).

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - `start`=1 and `lo`<=`hi`: latch `hi`, `x`<=`lo`, `count`<=0, go to SCAN.
  - `start`=1 and `lo`>`hi` (empty range): `count`<=0, go to DONE directly, with no SCAN cycles.
  - `start`=0: remain in IDLE; `x` and `count` hold.
- SCAN, at each edge:
  - if `z`: `count`<=`count`+1, `hit`<=1, `hit_val`<=`x`; otherwise `hit`<=0.
  - if `x`==latched `hi`: go to DONE and leave `x` unchanged; otherwise `x`<=`x`+1.
- Termination is decided by comparison, not by wrap-around: `hi`=2^W−1 never wraps `x` to 0.
- `count` width W+1 holds the full-range maximum without overflow.
- DONE: `done`=1 for exactly one cycle, then IDLE. `count` holds until the next accepted start.
- `start` in SCAN or DONE is ignored; `lo`/`hi` changes during SCAN have no effect.
- Reset mid-scan abandons the scan immediately, with no `done` pulse.
- Reset values: state IDLE, `x`=0, `busy`=0, `done`=0, `count`=0, `hit`=0, `hit_val`=0, `max_prime`=0.

## Timing
- `x` is registered; `z` is evaluated in the same cycle `x` is stable.
- Combinational path: `x` reg → classifier → `z` → `count`/`hit` regs, one cycle.
- Let N = `hi`−`lo`+1. After the edge that accepts `start`:
  - `busy` is high for N cycles.
  - `done` is high in cycle N+1.
- Empty range: `done` is high in the cycle after the accepting edge; `busy` never rises.
- `hit` appears one cycle after its `x` value is presented, coincident with the updated `count`.
- The last possible `hit` coincides with `done`.
- Back-to-back: `start` held high is accepted again in the first IDLE cycle after `done`; gap between scans = 1 cycle.

## Configuration
- Macro `PRIME_SCAN_MAX_EN`.
- Defined: `max_prime` register is updated with `x` on every `hit` capture. Scan is ascending, so `max_prime` = last prime found. `max_prime` clears to 0 on each accepted start.
- Undefined: the register is not built; `max_prime` is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- Full range: `lo`=0, `hi`=15, `start` pulse:
  - `hit_val` sequence 2,3,5,7,11,13.
  - `count`=6 at `done`.
  - `busy` high 16 cycles; `done` in cycle 17.
  - `x` never wraps.
  - With `PRIME_SCAN_MAX_EN`: `max_prime`=13.
- Single-value ranges:
  - `lo`=`hi`=4: `busy` 1 cycle, `count`=0, no `hit`.
  - `lo`=`hi`=11: one `hit` with `hit_val`=11, `count`=1.
- Empty range: `lo`=9, `hi`=3 → `done` in the cycle after start, `count`=0, `busy` never high.
- Start during scan:
  - `lo`=0, `hi`=15 running; assert `start` with `lo`=14, `hi`=15 at cycle 5 → ignored, final `count`=6.
  - Then hold `start` → new scan begins 1 cycle after `done`, final `count`=0.
- Reset mid-scan: `rst` at the 8th SCAN cycle → next cycle `busy`=0, `x`=0, `count`=0, no `done`. A following scan of 0..15 still yields `count`=6.

Source files
------------

// File: rtl/prime_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : prime_scan_if
//  Purpose  : Request/result bundle between a range scanner and its user,
//             plus the x/z link to the combinational prime classifier.
//  Revision : 1.0
// ============================================================================
interface prime_scan_if #(
    parameter int W = 4
);
    logic         start;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [W-1:0] x;
    logic         z;
    logic         busy;
    logic         done;
    logic [W:0]   count;
    logic         hit;
    logic [W-1:0] hit_val;
    logic [W-1:0] max_prime;

    modport master (
        output start, lo, hi, z,
        input  x, busy, done, count, hit, hit_val, max_prime
    );

    modport slave (
        input  start, lo, hi, z,
        output x, busy, done, count, hit, hit_val, max_prime
    );
endinterface
`default_nettype wire

// File: rtl/prime_scan.sv
`default_nettype none
// ============================================================================
//  Module   : prime_scan
//  Purpose  : Walks lo..hi through the prime classifier one value per clock,
//             counting and reporting primes. Optional macro PRIME_SCAN_MAX_EN
//             builds the max_prime register (tied to 0 otherwise).
//  Revision : 1.0
// ============================================================================
module prime_scan #(
    parameter int W = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    prime_scan_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_state;
    logic [W-1:0] r_x;
    logic [W-1:0] r_hi;
    logic [W-1:0] r_hit_val;
    logic [W:0]   r_count;
    logic         r_busy;
    logic         r_done;
    logic         r_hit;
`ifdef PRIME_SCAN_MAX_EN
    logic [W-1:0] r_max;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_hi      <= '0;
            r_hit_val <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hit     <= 1'b0;
`ifdef PRIME_SCAN_MAX_EN
            r_max     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_hit  <= 1'b0;
                    if (bus.start) begin
                        r_count <= '0;
`ifdef PRIME_SCAN_MAX_EN
                        r_max   <= '0;
`endif
                        if (bus.lo <= bus.hi) begin
                            r_hi    <= bus.hi;
                            r_x     <= bus.lo;
                            r_busy  <= 1'b1;
                            r_state <= S_SCAN;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_SCAN: begin
                    if (bus.z) begin
                        r_count   <= r_count + (W+1)'(1);
                        r_hit     <= 1'b1;
                        r_hit_val <= r_x;
`ifdef PRIME_SCAN_MAX_EN
                        r_max     <= r_x;
`endif
                    end else begin
                        r_hit <= 1'b0;
                    end
                    // Stop by comparison so hi = all-ones never wraps x.
                    if (r_x == r_hi) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_x <= r_x + W'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_hit   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_hit   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.x       = r_x;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.count   = r_count;
    assign bus.hit     = r_hit;
    assign bus.hit_val = r_hit_val;
`ifdef PRIME_SCAN_MAX_EN
    assign bus.max_prime = r_max;
`else
    assign bus.max_prime = '0;
`endif
endmodule
`default_nettype wire
